tr_manual_step_seq: RTL
=======================

Name: tr_manual_step_seq

Overview:
- Sequences the TR step/direction driver in manual mode.
- Turns the single-cycle stop/start/start_N command strobes and the period_MANUAL, PULSE_NUMBER and dir_MANUAL settings from the command/parameter register block into a timed step pulse train.
- Sits between the register block and the TR motor-driver pins.
- Reports busy, completion, a parameter error and the count of formed pulses back to software.

Parameters:
- WIDTH_C_P, 16: base width; all counters and parameter inputs are 2*WIDTH_C_P bits.
- PW, 50: step high time in clk cycles (1 us at 50 MHz), >=1.
- DIR_SETUP, 25: cycles from direction latch to first step rising edge, >=1.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- stop  in  1  single-cycle strobe: abort the current run.
- start  in  1  single-cycle strobe: start a continuous run.
- start_N  in  1  single-cycle strobe: start a run of PULSE_NUMBER pulses.
- dir_MANUAL  in  1  requested direction, sampled on an accepted start.
- count_MANUAL  in  1  enables pulse_cnt increments.
- period_MANUAL  in  2*WIDTH_C_P  step period in clk cycles, rising edge to rising edge.
- PULSE_NUMBER  in  2*WIDTH_C_P  pulse count for start_N.
- step  out  1  step pulse to the driver (registered).
- dir  out  1  direction to the driver (registered).
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when an N-run completes or an N=0 request is rejected.
- err_param  out  1  sticky flag: last accepted request was clamped or invalid.
- pulse_cnt  out  2*WIDTH_C_P  number of step rising edges formed in the current run.

Behaviour:
- Reset values: step=0, dir=0, busy=0, done=0, err_param=0, pulse_cnt=0, state=IDLE. Reset mid-run aborts immediately; it has priority over everything.
- States: IDLE, SETUP, HIGH, LOW. A mode flag selects CONT or NUM.
- Command priority in the same cycle: stop > start_N > start.
- stop in any state: next state IDLE, step=0 at the next edge (a high pulse is truncated), no done, pulse_cnt holds.
- start or start_N while busy: ignored.
- Accepted start (in IDLE):
  - Latch dir<=dir_MANUAL.
  - Latch period_eff = max(period_MANUAL, 2*PW), unsigned compare.
  - err_param <= (period_MANUAL < 2*PW).
  - pulse_cnt <= 0; mode=CONT; go to SETUP.
- Accepted start_N (in IDLE):
  - If PULSE_NUMBER==0: stay IDLE, done=1 for the next cycle, err_param=1, nothing else changes.
  - Otherwise: same latching as start, plus remaining<=PULSE_NUMBER; mode=NUM; go to SETUP.
- dir_MANUAL, period_MANUAL and PULSE_NUMBER changes during a run have no effect until the next accepted start.
- SETUP: lasts exactly DIR_SETUP cycles with step=0, then HIGH.
- HIGH: step=1 for exactly PW cycles.
  - On the first HIGH cycle, if count_MANUAL=1, pulse_cnt increments, saturating at all-ones.
  - In NUM mode, remaining decrements on the last HIGH cycle.
- LOW: step=0 for exactly period_eff-PW cycles. At its end:
  - NUM mode with remaining==0: go to IDLE and assert done for one cycle, in the first IDLE cycle.
  - Otherwise: go to HIGH.
- Timing, strobe accepted at edge T0:
  - busy=1 and dir valid from T0+1.
  - First step rise at T0+1+DIR_SETUP.
  - Subsequent rises every period_eff cycles.
- CONT mode runs until stop or rst.
- busy is high in SETUP/HIGH/LOW and low in IDLE, including the done cycle.
- err_param holds until the next accepted start/start_N re-evaluates it.

Test Plan:
Bench parameters: PW=4, DIR_SETUP=3.
1. start_N, N=3, period=10, dir_MANUAL=1, count_MANUAL=1, strobe at cycle 0 -> dir=1/busy=1 from cycle 1; step high cycles 4-7, 14-17, 24-27; done=1 and busy=0 at cycle 34; pulse_cnt=3; err_param=0.
2. start, period=8, then stop at cycle 13 (mid-HIGH) -> step rises at 4 and 12, step=0 and busy=0 from cycle 14, done never asserted, pulse_cnt=2.
3. start_N, N=2, period=3 -> period clamped to 8: rises at 4 and 12, done at 20, err_param=1; a following valid start_N (period=10) clears err_param.
4. start_N with PULSE_NUMBER=0 -> no step, busy stays 0, done=1 for one cycle at cycle 1, err_param=1.
5. During a CONT run: toggle dir_MANUAL, change period_MANUAL, strobe start_N -> dir and period unchanged, no restart. In IDLE, stop+start in the same cycle -> remains IDLE.
6. NUM run N=5 with count_MANUAL=0, then rst asserted at cycle 15 -> pulse_cnt=0 throughout; all outputs at reset values at cycle 16; no done.

Source files
------------

// File: rtl/tr_manual_step_seq.sv
// -----------------------------------------------------------------------------
// tr_manual_step_seq
//
// Manual-mode sequencer for the TR step/direction motor driver. It turns the
// single-cycle command strobes (stop, start, start_N) and the manual settings
// from the register block into a timed step pulse train.
//
// Run timeline, with the accepting strobe sampled at edge T0:
//   T0+1 .. T0+DIR_SETUP   : SETUP, direction driven, step low
//   then PW cycles         : HIGH, step high
//   then period_eff-PW     : LOW, step low; repeat HIGH/LOW
// In NUM mode the run ends after PULSE_NUMBER pulses, with a one-cycle done
// pulse in the first IDLE cycle. In CONT mode the run only ends on stop or rst.
//
// Ports:
//   clk           system clock (50 MHz)
//   rst           synchronous, active-high reset
//   stop          strobe: abort the current run (highest priority)
//   start         strobe: start a continuous run
//   start_N       strobe: start a run of PULSE_NUMBER pulses
//   dir_MANUAL    requested direction, latched on an accepted start
//   count_MANUAL  enables pulse_cnt increments
//   period_MANUAL step period in clk cycles, rise to rise
//   PULSE_NUMBER  pulse count for start_N
//   step          registered step pulse to the driver
//   dir           registered direction to the driver
//   busy          high while a run is in progress
//   done          one-cycle pulse: N-run completed or N=0 request rejected
//   err_param     sticky: last accepted request was clamped or invalid
//   pulse_cnt     step rising edges formed in the current run (saturating)
// -----------------------------------------------------------------------------
module tr_manual_step_seq #(
    parameter int unsigned WIDTH_C_P = 16,
    parameter int unsigned PW        = 50,
    parameter int unsigned DIR_SETUP = 25
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stop,
    input  logic                   start,
    input  logic                   start_N,
    input  logic                   dir_MANUAL,
    input  logic                   count_MANUAL,
    input  logic [2*WIDTH_C_P-1:0] period_MANUAL,
    input  logic [2*WIDTH_C_P-1:0] PULSE_NUMBER,
    output logic                   step,
    output logic                   dir,
    output logic                   busy,
    output logic                   done,
    output logic                   err_param,
    output logic [2*WIDTH_C_P-1:0] pulse_cnt
);

    localparam int unsigned CW = 2 * WIDTH_C_P;

    // Shortest legal period: equal high and low time.
    localparam logic [CW-1:0] MinPeriod = CW'(2 * PW);
    // Timers count down to zero, so each phase loads its length minus one.
    localparam logic [CW-1:0] SetupLast = CW'(DIR_SETUP - 1);
    localparam logic [CW-1:0] HighLast  = CW'(PW - 1);
    localparam logic [CW-1:0] PwLen     = CW'(PW);
    localparam logic [CW-1:0] One       = CW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow
    } state_e;

    state_e          state_q;
    logic            mode_num_q;
    logic [CW-1:0]   timer_q;
    logic [CW-1:0]   remaining_q;
    logic [CW-1:0]   period_eff_q;
    logic            step_q;
    logic            dir_q;
    logic            done_q;
    logic            err_q;
    logic [CW-1:0]   pulse_cnt_q;

    // Next-state helpers evaluated from the current inputs and registers.
    logic            period_short_d;
    logic [CW-1:0]   period_eff_d;
    logic [CW-1:0]   low_last_d;
    logic [CW-1:0]   pulse_cnt_d;

    always_comb begin
        period_short_d = (period_MANUAL < MinPeriod);
        period_eff_d   = period_short_d ? MinPeriod : period_MANUAL;
        // period_eff_q >= 2*PW, so the low phase is always at least PW long.
        low_last_d     = period_eff_q - PwLen - One;
        pulse_cnt_d    = pulse_cnt_q;
        if (count_MANUAL && (pulse_cnt_q != {CW{1'b1}})) begin
            pulse_cnt_d = pulse_cnt_q + One;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mode_num_q   <= 1'b0;
            timer_q      <= '0;
            remaining_q  <= '0;
            period_eff_q <= '0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            pulse_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                // Abort truncates a high pulse; pulse_cnt keeps its value.
                state_q <= StIdle;
                step_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_N) begin
                            if (PULSE_NUMBER == '0) begin
                                // Rejected request: report it, stay idle.
                                done_q <= 1'b1;
                                err_q  <= 1'b1;
                            end else begin
                                state_q      <= StSetup;
                                mode_num_q   <= 1'b1;
                                remaining_q  <= PULSE_NUMBER;
                                dir_q        <= dir_MANUAL;
                                period_eff_q <= period_eff_d;
                                err_q        <= period_short_d;
                                pulse_cnt_q  <= '0;
                                timer_q      <= SetupLast;
                            end
                        end else if (start) begin
                            state_q      <= StSetup;
                            mode_num_q   <= 1'b0;
                            dir_q        <= dir_MANUAL;
                            period_eff_q <= period_eff_d;
                            err_q        <= period_short_d;
                            pulse_cnt_q  <= '0;
                            timer_q      <= SetupLast;
                        end
                    end

                    StSetup: begin
                        if (timer_q == '0) begin
                            // Counting at the rise makes pulse_cnt move with step.
                            state_q     <= StHigh;
                            step_q      <= 1'b1;
                            timer_q     <= HighLast;
                            pulse_cnt_q <= pulse_cnt_d;
                        end else begin
                            timer_q <= timer_q - One;
                        end
                    end

                    StHigh: begin
                        if (timer_q == '0) begin
                            state_q <= StLow;
                            step_q  <= 1'b0;
                            timer_q <= low_last_d;
                            if (mode_num_q) begin
                                remaining_q <= remaining_q - One;
                            end
                        end else begin
                            timer_q <= timer_q - One;
                        end
                    end

                    StLow: begin
                        if (timer_q == '0) begin
                            if (mode_num_q && (remaining_q == '0)) begin
                                state_q <= StIdle;
                                done_q  <= 1'b1;
                            end else begin
                                state_q     <= StHigh;
                                step_q      <= 1'b1;
                                timer_q     <= HighLast;
                                pulse_cnt_q <= pulse_cnt_d;
                            end
                        end else begin
                            timer_q <= timer_q - One;
                        end
                    end

                    default: begin
                        state_q <= StIdle;
                        step_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign step      = step_q;
    assign dir       = dir_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err_param = err_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule
